// File: rtl/surf_wb_intercon_if.sv
// Bus bundle for the SURF WISHBONE interconnect: master-side strobes and
// responses, shared slave-window bus with per-window strobes, and the RFDC window.
// Port summary (directions as seen by the interconnect through modport slave):
//   m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_i/m_sel_i  in   per-master request, flattened
//   m_ack_o/m_err_o/m_dat_o                         out  per-master response, flattened
//   s_cyc_o/s_stb_o                                 out  per-window strobes
//   s_we_o/s_adr_o/s_dat_o/s_sel_o                  out  shared window bus
//   s_ack_i/s_dat_i                                 in   per-window response, flattened
//   rfdc_cyc_o/rfdc_stb_o/rfdc_we_o/rfdc_adr_o/rfdc_dat_o/rfdc_sel_o  out  RFDC request
//   rfdc_ack_i/rfdc_dat_i                           in   RFDC response
// Modport master is the environment view (bus masters plus the slave windows).
interface surf_wb_intercon_if #(
    parameter int NUM_MASTERS     = 2,
    parameter int NUM_SLAVES      = 4,
    parameter int ADDR_BITS       = 22,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int RFDC_ADDR_BITS  = 17,
    parameter int DATA_BITS       = 32
);
    localparam int SW = DATA_BITS / 8;

    logic [NUM_MASTERS-1:0]           m_cyc_i;
    logic [NUM_MASTERS-1:0]           m_stb_i;
    logic [NUM_MASTERS-1:0]           m_we_i;
    logic [NUM_MASTERS*ADDR_BITS-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_BITS-1:0] m_dat_i;
    logic [NUM_MASTERS*SW-1:0]        m_sel_i;
    logic [NUM_MASTERS-1:0]           m_ack_o;
    logic [NUM_MASTERS-1:0]           m_err_o;
    logic [NUM_MASTERS*DATA_BITS-1:0] m_dat_o;

    logic [NUM_SLAVES-1:0]            s_cyc_o;
    logic [NUM_SLAVES-1:0]            s_stb_o;
    logic                             s_we_o;
    logic [SLAVE_ADDR_BITS-1:0]       s_adr_o;
    logic [DATA_BITS-1:0]             s_dat_o;
    logic [SW-1:0]                    s_sel_o;
    logic [NUM_SLAVES-1:0]            s_ack_i;
    logic [NUM_SLAVES*DATA_BITS-1:0]  s_dat_i;

    logic                             rfdc_cyc_o;
    logic                             rfdc_stb_o;
    logic                             rfdc_we_o;
    logic [RFDC_ADDR_BITS-1:0]        rfdc_adr_o;
    logic [DATA_BITS-1:0]             rfdc_dat_o;
    logic [SW-1:0]                    rfdc_sel_o;
    logic                             rfdc_ack_i;
    logic [DATA_BITS-1:0]             rfdc_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_dat_i,
        output rfdc_cyc_o, rfdc_stb_o, rfdc_we_o, rfdc_adr_o, rfdc_dat_o, rfdc_sel_o,
        input  rfdc_ack_i, rfdc_dat_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_dat_i,
        input  rfdc_cyc_o, rfdc_stb_o, rfdc_we_o, rfdc_adr_o, rfdc_dat_o, rfdc_sel_o,
        output rfdc_ack_i, rfdc_dat_i
    );
endinterface

// File: rtl/surf_wb_intercon.sv
// WISHBONE classic interconnect for the SURF 22-bit register space: round-robin
// arbitration of NUM_MASTERS masters onto NUM_SLAVES 4 kB windows plus the RFDC
// upper half, with unmapped-address error, bus-hang timeout and sticky fault flag.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; bus (modport slave)
// carries all master/slave/RFDC signals; grant_o one-hot grant (0 when idle);
// timeout_o sticky timeout flag, cleared by timeout_clr_i (a new timeout wins).
module surf_wb_intercon #(
    parameter int                   NUM_MASTERS     = 2,
    parameter int                   NUM_SLAVES      = 4,
    parameter int                   ADDR_BITS       = 22,
    parameter int                   SLAVE_ADDR_BITS = 12,
    parameter int                   RFDC_ADDR_BITS  = 17,
    parameter int                   DATA_BITS       = 32,
    parameter int                   TIMEOUT         = 255,
    parameter logic [DATA_BITS-1:0] TIMEOUT_DATA    = 32'hDEADBEEF,
    parameter logic [DATA_BITS-1:0] UNMAPPED_DATA   = 32'hBADADD00
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    surf_wb_intercon_if.slave      bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o,
    input  logic                   timeout_clr_i
);
    localparam int AW   = ADDR_BITS;
    localparam int DW   = DATA_BITS;
    localparam int SW   = DATA_BITS / 8;
    localparam int IDXW = ADDR_BITS - 1 - SLAVE_ADDR_BITS;
    localparam int PW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          rr_q, rr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   unm_q, unm_d;
    logic                   timeout_q, timeout_d;

    logic                   gcyc, gstb, gwe;
    logic [AW-1:0]          gadr;
    logic [DW-1:0]          gdat;
    logic [SW-1:0]          gsel;
    logic                   active, is_rfdc, unmapped;
    logic [IDXW-1:0]        idx;
    logic                   req_stb, tgt_stb, tgt_ack, at_limit, tmo;
    logic [DW-1:0]          tgt_dat, rsp_dat;
    logic                   rsp_ack, rsp_err, unm_ack;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] m_ack, m_err;
    logic [NUM_MASTERS*DW-1:0] m_dat;
    logic [NUM_SLAVES-1:0]  s_cyc, s_stb;
    logic                   found;

    // Granted-master mux; grant is one-hot so an OR-reduction suffices.
    always_comb begin
        gcyc = 1'b0;
        gstb = 1'b0;
        gwe  = 1'b0;
        gadr = '0;
        gdat = '0;
        gsel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                gcyc |= bus.m_cyc_i[i];
                gstb |= bus.m_stb_i[i];
                gwe  |= bus.m_we_i[i];
                gadr |= bus.m_adr_i[i*AW +: AW];
                gdat |= bus.m_dat_i[i*DW +: DW];
                gsel |= bus.m_sel_i[i*SW +: SW];
            end
        end
    end

    assign active   = (state_q == ACTIVE);
    assign is_rfdc  = gadr[AW-1];
    assign idx      = gadr[AW-2:SLAVE_ADDR_BITS];
    assign unmapped = !is_rfdc && (idx >= IDXW'(NUM_SLAVES));
    assign req_stb  = active && gcyc && gstb;
    assign tgt_stb  = req_stb && !unmapped;
    assign at_limit = (cnt_q == CW'(TIMEOUT));

    // Target response select and per-window strobe decode.
    always_comb begin
        tgt_ack = 1'b0;
        tgt_dat = '0;
        s_cyc   = '0;
        s_stb   = '0;
        if (is_rfdc) begin
            tgt_ack = bus.rfdc_ack_i;
            tgt_dat = bus.rfdc_dat_i;
        end else begin
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (idx == IDXW'(k)) begin
                    tgt_ack  = bus.s_ack_i[k];
                    tgt_dat  = bus.s_dat_i[k*DW +: DW];
                    s_cyc[k] = active && gcyc;
                    s_stb[k] = tgt_stb && !at_limit;
                end
            end
        end
    end

    // Timeout only fires if the slave did not ack in that same cycle. The
    // forced-low strobe depends on the count alone so a slave whose ack is
    // combinational on stb cannot form a loop through this block.
    assign tmo     = tgt_stb && at_limit && !tgt_ack;
    assign unm_ack = req_stb && unmapped && unm_q;
    assign rsp_ack = (tgt_stb && tgt_ack) || tmo || unm_ack;
    assign rsp_err = tmo || unm_ack;
    assign rsp_dat = tmo      ? TIMEOUT_DATA :
                     unmapped ? UNMAPPED_DATA : tgt_dat;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        m_dat = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                m_ack[i]           = rsp_ack;
                m_err[i]           = rsp_err;
                m_dat[i*DW +: DW]  = rsp_dat;
            end
        end
    end

    assign req = bus.m_cyc_i & bus.m_stb_i;

    // Next-state: arbitration, release, timeout counter and fault flag.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        found     = 1'b0;
        cnt_d     = (tgt_stb && !tgt_ack && !at_limit) ? cnt_q + CW'(1) : '0;
        unm_d     = req_stb && unmapped && !unm_q;
        timeout_d = tmo ? 1'b1 : (timeout_clr_i ? 1'b0 : timeout_q);
        unique case (state_q)
            IDLE: begin
                for (int off = 0; off < NUM_MASTERS; off++) begin
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (!found && req[i] &&
                            i == ((int'(rr_q) + off) % NUM_MASTERS)) begin
                            found      = 1'b1;
                            grant_d    = '0;
                            grant_d[i] = 1'b1;
                            rr_d       = PW'((i + 1) % NUM_MASTERS);
                        end
                    end
                end
                if (found) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!gcyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            unm_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            unm_q     <= unm_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.m_ack_o    = m_ack;
    assign bus.m_err_o    = m_err;
    assign bus.m_dat_o    = m_dat;
    assign bus.s_cyc_o    = s_cyc;
    assign bus.s_stb_o    = s_stb;
    assign bus.s_we_o     = gwe;
    assign bus.s_adr_o    = gadr[SLAVE_ADDR_BITS-1:0];
    assign bus.s_dat_o    = gdat;
    assign bus.s_sel_o    = gsel;
    assign bus.rfdc_cyc_o = active && gcyc && is_rfdc;
    assign bus.rfdc_stb_o = tgt_stb && !at_limit && is_rfdc;
    assign bus.rfdc_we_o  = gwe;
    assign bus.rfdc_adr_o = gadr[RFDC_ADDR_BITS-1:0];
    assign bus.rfdc_dat_o = gdat;
    assign bus.rfdc_sel_o = gsel;
    assign grant_o        = grant_q;
    assign timeout_o      = timeout_q;
endmodule

// File: tb/tb_surf_wb_intercon.sv
// Directed bench for surf_wb_intercon: arbitration, routing, unmapped error,
// timeout, sticky flag and asynchronous reset.
module tb_surf_wb_intercon;
    logic       clk;
    logic       rst;
    logic       clr;
    logic [1:0] grant;
    logic       tmo_flag;
    int         checks;
    int         failures;
    logic       early;

    surf_wb_intercon_if #(
        .NUM_MASTERS(2), .NUM_SLAVES(4), .ADDR_BITS(22),
        .SLAVE_ADDR_BITS(12), .RFDC_ADDR_BITS(17), .DATA_BITS(32)
    ) bus ();

    surf_wb_intercon dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .bus          (bus),
        .grant_o      (grant),
        .timeout_o    (tmo_flag),
        .timeout_clr_i(clr)
    );

    initial clk = 1'b0;
    always #8 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreq(input int i, input logic c, input logic we,
                        input logic [21:0] a, input logic [31:0] d);
        bus.m_cyc_i[i]           = c;
        bus.m_stb_i[i]           = c;
        bus.m_we_i[i]            = we;
        bus.m_adr_i[i*22 +: 22]  = a;
        bus.m_dat_i[i*32 +: 32]  = d;
        bus.m_sel_i[i*4 +: 4]    = 4'hF;
    endtask

    task automatic sack(input int k, input logic a, input logic [31:0] d);
        bus.s_ack_i[k]          = a;
        bus.s_dat_i[k*32 +: 32] = d;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        early          = 1'b0;
        bus.m_cyc_i    = '0;
        bus.m_stb_i    = '0;
        bus.m_we_i     = '0;
        bus.m_adr_i    = '0;
        bus.m_dat_i    = '0;
        bus.m_sel_i    = '0;
        bus.s_ack_i    = '0;
        bus.s_dat_i    = '0;
        bus.rfdc_ack_i = 1'b0;
        bus.rfdc_dat_i = '0;
        clr            = 1'b0;
        rst            = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_tmo", tmo_flag, 1'b0);
        chk("rst_sstb", bus.s_stb_o, 4'b0000);
        chk("rst_mack", bus.m_ack_o, 2'b00);
        rst = 1'b0;
        tick();

        // Both masters request together from reset: M0 first, then M1.
        mreq(0, 1'b1, 1'b0, 22'h000000, 32'h0);
        mreq(1, 1'b1, 1'b0, 22'h001008, 32'h0);
        tick();
        chk("rr1_grant_m0", grant, 2'b01);
        chk("rr1_sstb", bus.s_stb_o, 4'b0001);
        sack(0, 1'b1, 32'h11110000);
        #1;
        chk("rr1_m0_ack", bus.m_ack_o, 2'b01);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(0, 1'b0, 32'h0);
        #1;
        chk("release_scyc", bus.s_cyc_o, 4'b0000);
        tick();
        chk("release_idle", grant, 2'b00);
        tick();
        chk("rr1_grant_m1", grant, 2'b10);
        sack(1, 1'b1, 32'hCAFE0001);
        #1;
        chk("rr1_m1_ack", bus.m_ack_o, 2'b10);
        chk("rr1_m1_dat", bus.m_dat_o[63:32], 32'hCAFE0001);
        chk("nongrant_dat", bus.m_dat_o[31:0], 32'h0);
        tick();
        mreq(1, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(1, 1'b0, 32'h0);
        tick();

        // M0 alone, so the pointer moves past M0.
        mreq(0, 1'b1, 1'b0, 22'h000000, 32'h0);
        tick();
        sack(0, 1'b1, 32'h0);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(0, 1'b0, 32'h0);
        tick();

        // Both request again: M1 first this time.
        mreq(0, 1'b1, 1'b0, 22'h000000, 32'h0);
        mreq(1, 1'b1, 1'b0, 22'h001008, 32'h0);
        tick();
        chk("rr2_grant_m1", grant, 2'b10);
        sack(1, 1'b1, 32'h0);
        tick();
        mreq(1, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(1, 1'b0, 32'h0);
        tick();
        tick();
        chk("rr2_grant_m0", grant, 2'b01);
        sack(0, 1'b1, 32'h0);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(0, 1'b0, 32'h0);
        tick();

        // M0 read 0x000004, slave0 acks in the third granted cycle.
        mreq(0, 1'b1, 1'b0, 22'h000004, 32'h0);
        #1;
        chk("grant_latency", grant, 2'b00);
        tick();
        chk("rd_grant", grant, 2'b01);
        chk("rd_sadr", bus.s_adr_o, 12'h004);
        chk("rd_sstb", bus.s_stb_o, 4'b0001);
        chk("rd_noack", bus.m_ack_o, 2'b00);
        tick();
        tick();
        sack(0, 1'b1, 32'h12345678);
        #1;
        chk("rd_ack", bus.m_ack_o, 2'b01);
        chk("rd_err", bus.m_err_o, 2'b00);
        chk("rd_dat", bus.m_dat_o[31:0], 32'h12345678);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(0, 1'b0, 32'h0);
        tick();

        // M1 write to the RFDC window.
        mreq(1, 1'b1, 1'b1, 22'h200010, 32'hA5A5A5A5);
        tick();
        chk("rfdc_stb", bus.rfdc_stb_o, 1'b1);
        chk("rfdc_adr", bus.rfdc_adr_o, 17'h00010);
        chk("rfdc_we", bus.rfdc_we_o, 1'b1);
        chk("rfdc_dat", bus.rfdc_dat_o, 32'hA5A5A5A5);
        chk("rfdc_sstb", bus.s_stb_o, 4'b0000);
        bus.rfdc_ack_i = 1'b1;
        #1;
        chk("rfdc_ack", bus.m_ack_o, 2'b10);
        tick();
        mreq(1, 1'b0, 1'b0, 22'h0, 32'h0);
        bus.rfdc_ack_i = 1'b0;
        tick();

        // Unmapped window 5.
        mreq(0, 1'b1, 1'b0, 22'h005000, 32'h0);
        tick();
        chk("unm_scyc", bus.s_cyc_o, 4'b0000);
        chk("unm_sstb", bus.s_stb_o, 4'b0000);
        chk("unm_first_noack", bus.m_ack_o, 2'b00);
        tick();
        chk("unm_ack", bus.m_ack_o, 2'b01);
        chk("unm_err", bus.m_err_o, 2'b01);
        chk("unm_dat", bus.m_dat_o[31:0], 32'hBADADD00);
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        tick();

        // Slave2 never acks: error-ack on stb cycle 255.
        mreq(0, 1'b1, 1'b0, 22'h002000, 32'h0);
        tick();
        early = 1'b0;
        for (int n = 0; n < 255; n++) begin
            if (bus.m_ack_o !== 2'b00 || bus.s_stb_o !== 4'b0100) early = 1'b1;
            tick();
        end
        chk("tmo_wait", early, 1'b0);
        chk("tmo_ack", bus.m_ack_o, 2'b01);
        chk("tmo_err", bus.m_err_o, 2'b01);
        chk("tmo_dat", bus.m_dat_o[31:0], 32'hDEADBEEF);
        chk("tmo_sstb_low", bus.s_stb_o, 4'b0000);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        chk("tmo_flag_set", tmo_flag, 1'b1);
        tick();
        tick();
        chk("tmo_flag_sticky", tmo_flag, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("tmo_flag_clr", tmo_flag, 1'b0);

        // Slave ack exactly on cycle 255 wins over the timeout.
        mreq(0, 1'b1, 1'b0, 22'h002000, 32'h0);
        tick();
        for (int n = 0; n < 255; n++) tick();
        sack(2, 1'b1, 32'h22222222);
        #1;
        chk("late_ack", bus.m_ack_o, 2'b01);
        chk("late_err", bus.m_err_o, 2'b00);
        chk("late_dat", bus.m_dat_o[31:0], 32'h22222222);
        tick();
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        sack(2, 1'b0, 32'h0);
        chk("late_no_flag", tmo_flag, 1'b0);
        tick();

        // Reset mid-transaction; pointer sits past M0 beforehand.
        mreq(0, 1'b1, 1'b0, 22'h003000, 32'h0);
        tick();
        chk("pre_rst_sstb", bus.s_stb_o, 4'b1000);
        rst = 1'b1;
        sack(3, 1'b1, 32'h33333333);
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_sstb", bus.s_stb_o, 4'b0000);
        chk("arst_mack", bus.m_ack_o, 2'b00);
        sack(3, 1'b0, 32'h0);
        mreq(0, 1'b1, 1'b0, 22'h000000, 32'h0);
        mreq(1, 1'b1, 1'b0, 22'h001000, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_rr", grant, 2'b01);
        mreq(0, 1'b0, 1'b0, 22'h0, 32'h0);
        mreq(1, 1'b0, 1'b0, 22'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
